// File: rtl/pmod_stand_spi_solo_pkg.sv
// Shared types and CLS command constants for the PmodCLS SPI responder.
// The display line type packs 16 ASCII bytes with column 0 in the MSB byte.
package pmod_stand_spi_solo_pkg;

   typedef logic [127:0] t_pmod_cls_ascii_line_16;

   typedef enum logic [1:0] {
      ST_RSP_TEXT = 2'd0,
      ST_RSP_ESC  = 2'd1,
      ST_RSP_CSI  = 2'd2
   } t_rsp_state;

   localparam logic [7:0] C_CLS_ESC      = 8'h1B;
   localparam logic [7:0] C_CLS_LBRACKET = 8'h5B;
   localparam logic [7:0] C_CLS_CLEAR    = 8'h6A;
   localparam logic [7:0] C_CLS_HOME     = 8'h48;
   localparam logic [7:0] C_CLS_SEMI     = 8'h3B;
   localparam logic [7:0] C_CLS_DIGIT_0  = 8'h30;
   localparam logic [7:0] C_CLS_DIGIT_9  = 8'h39;
   localparam logic [7:0] C_CLS_SPACE    = 8'h20;
   localparam logic [7:0] C_CLS_PRINT_HI = 8'h7E;

   localparam t_pmod_cls_ascii_line_16 C_CLS_BLANK_LINE = {16{C_CLS_SPACE}};

   function automatic logic cls_is_digit(input logic [7:0] b);
      return (b >= C_CLS_DIGIT_0) && (b <= C_CLS_DIGIT_9);
   endfunction

   function automatic logic cls_is_printable(input logic [7:0] b);
      return (b >= C_CLS_SPACE) && (b <= C_CLS_PRINT_HI);
   endfunction

endpackage

// File: rtl/pmod_cls_spi_responder_if.sv
// SPI wires from the initiator plus the received-byte stream of the responder.
// Byte stream is valid-only: o_byte is meaningful only while o_byte_valid is high, no ready/backpressure.
interface pmod_cls_spi_responder_if;
   logic       i_sck;
   logic       i_csn;
   logic       i_copi;
   logic       o_byte_valid;
   logic [7:0] o_byte;

   modport master (output i_sck, output i_csn, output i_copi,
                   input  o_byte_valid, input o_byte);
   modport slave  (input  i_sck, input  i_csn, input  i_copi,
                   output o_byte_valid, output o_byte);
endinterface

// File: rtl/pmod_spi_rx_byte_solo.sv
// SPI mode 0 byte receiver: synchronizes SCK/CS_N/COPI, detects SCK rising edges,
// shifts MSB first and strobes each completed byte for one cycle.
module pmod_spi_rx_byte_solo #(
   parameter int parm_sync_stages = 2
) (
   input  logic       i_ext_spi_clk_x,
   input  logic       i_srst_n,
   input  logic       i_sck,
   input  logic       i_csn,
   input  logic       i_copi,
   output logic       o_byte_valid,
   output logic [7:0] o_byte
);

   logic [parm_sync_stages-1:0] sck_sync;
   logic [parm_sync_stages-1:0] csn_sync;
   logic [parm_sync_stages-1:0] copi_sync;
   logic                        sck_prev;
   logic                        sck_s;
   logic                        csn_s;
   logic                        copi_s;
   logic                        sck_rise;
   logic [2:0]                  bit_cnt;
   logic [7:0]                  shift_reg;
   logic [7:0]                  shift_next;

   assign sck_s      = sck_sync[parm_sync_stages-1];
   assign csn_s      = csn_sync[parm_sync_stages-1];
   assign copi_s     = copi_sync[parm_sync_stages-1];
   assign sck_rise   = sck_s & ~sck_prev;
   assign shift_next = {shift_reg[6:0], copi_s};

   // Equal depth on all three lines keeps COPI aligned with the detected SCK edge.
   always_ff @(posedge i_ext_spi_clk_x) begin
      if (!i_srst_n) begin
         sck_sync  <= '0;
         csn_sync  <= '1;
         copi_sync <= '0;
         sck_prev  <= 1'b0;
      end else begin
         sck_sync[0]  <= i_sck;
         csn_sync[0]  <= i_csn;
         copi_sync[0] <= i_copi;
         for (int i = 1; i < parm_sync_stages; i++) begin
            sck_sync[i]  <= sck_sync[i-1];
            csn_sync[i]  <= csn_sync[i-1];
            copi_sync[i] <= copi_sync[i-1];
         end
         sck_prev <= sck_s;
      end
   end

   always_ff @(posedge i_ext_spi_clk_x) begin
      if (!i_srst_n) begin
         bit_cnt      <= 3'd0;
         shift_reg    <= 8'h00;
         o_byte_valid <= 1'b0;
         o_byte       <= 8'h00;
      end else begin
         o_byte_valid <= 1'b0;
         if (csn_s) begin
            bit_cnt <= 3'd0;
         end else if (sck_rise) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               o_byte_valid <= 1'b1;
               o_byte       <= shift_next;
            end
         end
      end
   end

endmodule

// File: rtl/pmod_cls_spi_responder.sv
// PmodCLS-style SPI display responder: receives bytes, parses text and ESC [ ... j/H
// sequences, and maintains two 16-column ASCII line buffers plus a cursor.
module pmod_cls_spi_responder
   import pmod_stand_spi_solo_pkg::*;
#(
   parameter int parm_sync_stages      = 2,
   parameter int parm_max_param_digits = 2
) (
   input  logic                    i_ext_spi_clk_x,
   input  logic                    i_srst_n,
   pmod_cls_spi_responder_if.slave bus,
   output logic                    o_clear_pulse,
   output t_pmod_cls_ascii_line_16 o_line1,
   output t_pmod_cls_ascii_line_16 o_line2,
   output logic                    o_cursor_row,
   output logic [3:0]              o_cursor_col,
   output logic                    o_seq_error,
   output t_rsp_state              o_parser_state
);

   localparam int DCW = $clog2(parm_max_param_digits + 1);
   localparam logic [DCW-1:0] MAX_DIGITS = DCW'(parm_max_param_digits);

   logic           rx_valid;
   logic [7:0]     rx_byte;
   t_rsp_state     state_q;
   t_rsp_state     state_d;
   logic [6:0]     param0_q;
   logic [6:0]     param1_q;
   logic           param_idx_q;
   logic [DCW-1:0] digit_cnt_q;
   logic [6:0]     acc_src;
   logic [6:0]     acc_next;
   logic [6:0]     wr_lsb;
   logic           digit_full;
   logic           act_write;
   logic           act_open;
   logic           act_digit;
   logic           act_semi;
   logic           act_clear;
   logic           act_home;
   logic           act_err;

   pmod_spi_rx_byte_solo #(
      .parm_sync_stages(parm_sync_stages)
   ) u_rx (
      .i_ext_spi_clk_x (i_ext_spi_clk_x),
      .i_srst_n        (i_srst_n),
      .i_sck           (bus.i_sck),
      .i_csn           (bus.i_csn),
      .i_copi          (bus.i_copi),
      .o_byte_valid    (rx_valid),
      .o_byte          (rx_byte)
   );

   assign bus.o_byte_valid = rx_valid;
   assign bus.o_byte       = rx_byte;
   assign o_parser_state   = state_q;

   assign digit_full = (digit_cnt_q >= MAX_DIGITS);
   assign acc_src    = param_idx_q ? param1_q : param0_q;
   assign acc_next   = acc_src * 7'd10 + {3'b000, rx_byte[3:0]};
   // Column 0 lives in the MSB byte, so the byte offset is (15 - col) * 8.
   assign wr_lsb     = {~o_cursor_col, 3'b000};

   always_ff @(posedge i_ext_spi_clk_x) begin
      if (!i_srst_n) state_q <= ST_RSP_TEXT;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (rx_valid) begin
         case (state_q)
            ST_RSP_TEXT: if (rx_byte == C_CLS_ESC) state_d = ST_RSP_ESC;
            ST_RSP_ESC:  state_d = (rx_byte == C_CLS_LBRACKET) ? ST_RSP_CSI : ST_RSP_TEXT;
            ST_RSP_CSI: begin
               state_d = ST_RSP_TEXT;
               if (cls_is_digit(rx_byte) && !digit_full)        state_d = ST_RSP_CSI;
               else if ((rx_byte == C_CLS_SEMI) && !param_idx_q) state_d = ST_RSP_CSI;
               else if (rx_byte == C_CLS_ESC)                    state_d = ST_RSP_ESC;
            end
            default: state_d = ST_RSP_TEXT;
         endcase
      end
   end

   always_comb begin
      act_write = 1'b0;
      act_open  = 1'b0;
      act_digit = 1'b0;
      act_semi  = 1'b0;
      act_clear = 1'b0;
      act_home  = 1'b0;
      act_err   = 1'b0;
      if (rx_valid) begin
         case (state_q)
            ST_RSP_TEXT: act_write = cls_is_printable(rx_byte);
            ST_RSP_ESC: begin
               act_open = (rx_byte == C_CLS_LBRACKET);
               act_err  = (rx_byte != C_CLS_LBRACKET);
            end
            ST_RSP_CSI: begin
               if (cls_is_digit(rx_byte)) begin
                  act_digit = !digit_full;
                  act_err   = digit_full;
               end else if (rx_byte == C_CLS_SEMI) begin
                  act_semi = !param_idx_q;
                  act_err  = param_idx_q;
               end else if (rx_byte == C_CLS_CLEAR) begin
                  act_clear = (param0_q == 7'd0);
                  act_err   = (param0_q != 7'd0);
               end else if (rx_byte == C_CLS_HOME) begin
                  act_home = 1'b1;
               end else if (rx_byte != C_CLS_ESC) begin
                  act_err = 1'b1;
               end
            end
            default: act_err = 1'b0;
         endcase
      end
   end

   // All effects of a byte land one cycle after its strobe.
   always_ff @(posedge i_ext_spi_clk_x) begin
      if (!i_srst_n) begin
         o_clear_pulse <= 1'b0;
         o_seq_error   <= 1'b0;
         o_line1       <= C_CLS_BLANK_LINE;
         o_line2       <= C_CLS_BLANK_LINE;
         o_cursor_row  <= 1'b0;
         o_cursor_col  <= 4'd0;
         param0_q      <= 7'd0;
         param1_q      <= 7'd0;
         param_idx_q   <= 1'b0;
         digit_cnt_q   <= '0;
      end else begin
         o_clear_pulse <= act_clear;
         o_seq_error   <= act_err;
         if (act_open) begin
            param0_q    <= 7'd0;
            param1_q    <= 7'd0;
            param_idx_q <= 1'b0;
            digit_cnt_q <= '0;
         end
         if (act_digit) begin
            if (param_idx_q) param1_q <= acc_next;
            else             param0_q <= acc_next;
            digit_cnt_q <= digit_cnt_q + 1'b1;
         end
         if (act_semi) begin
            param_idx_q <= 1'b1;
            digit_cnt_q <= '0;
         end
         if (act_write) begin
            if (o_cursor_row) o_line2[wr_lsb +: 8] <= rx_byte;
            else              o_line1[wr_lsb +: 8] <= rx_byte;
            if (o_cursor_col != 4'd15) o_cursor_col <= o_cursor_col + 4'd1;
         end
         if (act_clear) begin
            o_line1      <= C_CLS_BLANK_LINE;
            o_line2      <= C_CLS_BLANK_LINE;
            o_cursor_row <= 1'b0;
            o_cursor_col <= 4'd0;
         end
         if (act_home) begin
            o_cursor_row <= (param0_q != 7'd0);
            o_cursor_col <= (param1_q > 7'd15) ? 4'd15 : param1_q[3:0];
         end
      end
   end

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Bench for the PmodCLS SPI responder: byte-stream scoreboard, cursor vector table,
// and hand-written sequences for clear, home, errors, partial frames and mid-byte reset.
module tb_pmod_cls_spi_responder;
   import pmod_stand_spi_solo_pkg::*;

   logic                    clk = 1'b0;
   logic                    srst_n;
   logic                    clear_pulse;
   t_pmod_cls_ascii_line_16 line1;
   t_pmod_cls_ascii_line_16 line2;
   logic                    cursor_row;
   logic [3:0]              cursor_col;
   logic                    seq_error;
   t_rsp_state              parser_state;

   pmod_cls_spi_responder_if bus();

   pmod_cls_spi_responder dut (
      .i_ext_spi_clk_x (clk),
      .i_srst_n        (srst_n),
      .bus             (bus),
      .o_clear_pulse   (clear_pulse),
      .o_line1         (line1),
      .o_line2         (line2),
      .o_cursor_row    (cursor_row),
      .o_cursor_col    (cursor_col),
      .o_seq_error     (seq_error),
      .o_parser_state  (parser_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n_valid = 0;
   int n_clear = 0;
   int n_err   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] tx_q[$];

   t_pmod_cls_ascii_line_16 m_line1;
   t_pmod_cls_ascii_line_16 m_line2;
   logic                    m_row;
   logic [3:0]              m_col;

   typedef struct {
      logic [7:0] r;
      logic [7:0] c1;
      logic [7:0] c2;
      logic       er;
      logic [3:0] ec;
   } t_vec;
   t_vec vecs[6];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%0h req=%0h", name, act, req);
      end
   endtask

   // Scoreboard: every strobed byte must match the oldest byte sent.
   always @(negedge clk) begin
      logic [7:0] e;
      if (bus.o_byte_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL stray_byte act=%02h req=none", bus.o_byte);
         end else begin
            e = exp_q.pop_front();
            chk("byte_stream", bus.o_byte, e);
         end
      end
      if (clear_pulse) n_clear++;
      if (seq_error)   n_err++;
   end

   task automatic spi_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_copi = b[7-i];
         repeat (5) @(negedge clk);
         bus.i_sck = 1'b1;
         repeat (5) @(negedge clk);
         bus.i_sck = 1'b0;
      end
   endtask

   task automatic send_frame();
      logic [7:0] b;
      bus.i_csn = 1'b0;
      repeat (4) @(negedge clk);
      while (tx_q.size() > 0) begin
         b = tx_q.pop_front();
         exp_q.push_back(b);
         spi_bits(b, 8);
      end
      repeat (4) @(negedge clk);
      bus.i_csn = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
   endtask

   function automatic t_pmod_cls_ascii_line_16 str_line(input string s);
      t_pmod_cls_ascii_line_16 v;
      v = {16{8'h20}};
      for (int i = 0; i < s.len() && i < 16; i++) v[127-8*i -: 8] = s[i];
      return v;
   endfunction

   task automatic model_text(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         if (m_row) m_line2[127-8*m_col -: 8] = b;
         else       m_line1[127-8*m_col -: 8] = b;
         if (m_col != 4'd15) m_col = m_col + 4'd1;
      end
   endtask

   task automatic model_blank();
      m_line1 = {16{8'h20}};
      m_line2 = {16{8'h20}};
      m_row   = 1'b0;
      m_col   = 4'd0;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "_line1"}, line1, m_line1);
      chk({tag, "_line2"}, line2, m_line2);
      chk({tag, "_row"}, cursor_row, m_row);
      chk({tag, "_col"}, cursor_col, m_col);
   endtask

   initial begin
      int c0, e0, v0;
      logic [7:0] b;
      vecs[0] = '{8'h30, 8'h30, 8'h30, 1'b0, 4'd0};
      vecs[1] = '{8'h31, 8'h30, 8'h35, 1'b1, 4'd5};
      vecs[2] = '{8'h30, 8'h31, 8'h35, 1'b0, 4'd15};
      vecs[3] = '{8'h39, 8'h39, 8'h39, 1'b1, 4'd15};
      vecs[4] = '{8'h31, 8'h32, 8'h30, 1'b1, 4'd15};
      vecs[5] = '{8'h30, 8'h30, 8'h37, 1'b0, 4'd7};

      // Reset state
      srst_n = 1'b0;
      bus.i_sck = 1'b0;
      bus.i_csn = 1'b1;
      bus.i_copi = 1'b0;
      repeat (4) @(negedge clk);
      model_blank();
      chk("rst_valid", bus.o_byte_valid, 1'b0);
      chk("rst_byte", bus.o_byte, 8'h00);
      chk("rst_clear", clear_pulse, 1'b0);
      chk("rst_err", seq_error, 1'b0);
      chk("rst_state", parser_state, ST_RSP_TEXT);
      chk_all("rst");
      srst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Pre-fill then clear
      push_str("XYZ");
      send_frame();
      chk("prefill_line1", line1, str_line("XYZ"));
      c0 = n_clear;
      tx_q = '{8'h1B, 8'h5B, 8'h30, 8'h6A};
      send_frame();
      chk("clear_count", n_clear - c0, 1);
      chk_all("clear");

      // Home (0,0) then a 16-char line
      tx_q = '{8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h30, 8'h48};
      send_frame();
      push_str("ACL X:+0.000g   ");
      send_frame();
      m_line1 = str_line("ACL X:+0.000g   ");
      m_col = 4'd15;
      chk_all("acl");

      // Row 1, 20 'A' bytes saturating at col 15
      tx_q = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h30, 8'h30, 8'h48};
      send_frame();
      for (int i = 0; i < 20; i++) tx_q.push_back(8'h41);
      send_frame();
      m_line2 = {16{8'h41}};
      m_row = 1'b1;
      chk_all("row2_a");

      // Clear with non-zero parameter is an error
      c0 = n_clear;
      e0 = n_err;
      tx_q = '{8'h1B, 8'h5B, 8'h35, 8'h6A};
      send_frame();
      chk("bad_clear_err", n_err - e0, 1);
      chk("bad_clear_noclr", n_clear - c0, 0);
      chk_all("bad_clear");
      tx_q = '{8'h1B, 8'h5B, 8'h39, 8'h3B, 8'h39, 8'h39, 8'h48};
      send_frame();
      chk("clamp_row", cursor_row, 1'b1);
      chk("clamp_col", cursor_col, 4'd15);

      // Cursor positioning table
      e0 = n_err;
      for (int i = 0; i < 6; i++) begin
         tx_q = '{8'h1B, 8'h5B, vecs[i].r, 8'h3B, vecs[i].c1, vecs[i].c2, 8'h48};
         send_frame();
         chk($sformatf("vec%0d_row", i), cursor_row, vecs[i].er);
         chk($sformatf("vec%0d_col", i), cursor_col, vecs[i].ec);
      end
      chk("vec_no_err", n_err - e0, 0);
      m_row = 1'b0;
      m_col = 4'd7;

      // Too many digits, double ';', ESC followed by non-'['
      e0 = n_err;
      tx_q = '{8'h1B, 8'h5B, 8'h31, 8'h32, 8'h33};
      send_frame();
      tx_q = '{8'h1B, 8'h5B, 8'h3B, 8'h3B};
      send_frame();
      tx_q = '{8'h1B, 8'h41};
      send_frame();
      chk("seq_err_count", n_err - e0, 3);
      chk_all("seq_err");

      // Clear, then random text with a few ignored control bytes
      tx_q = '{8'h1B, 8'h5B, 8'h6A};
      send_frame();
      model_blank();
      chk_all("clear2");
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'h0D;
         else b = 8'($urandom_range(32, 126));
         tx_q.push_back(b);
         model_text(b);
      end
      send_frame();
      chk_all("random");

      // Partial frame of 5 bits is dropped, next frame byte still lands
      v0 = n_valid;
      bus.i_csn = 1'b0;
      repeat (4) @(negedge clk);
      spi_bits(8'hC3, 5);
      repeat (4) @(negedge clk);
      bus.i_csn = 1'b1;
      repeat (12) @(negedge clk);
      chk("partial_no_strobe", n_valid - v0, 0);
      tx_q = '{8'h41};
      send_frame();
      model_text(8'h41);
      chk("partial_one_strobe", n_valid - v0, 1);
      chk_all("partial");

      // Reset in the middle of 0x5A, then 0x42
      v0 = n_valid;
      bus.i_csn = 1'b0;
      repeat (4) @(negedge clk);
      spi_bits(8'h5A, 4);
      srst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_byte", bus.o_byte, 8'h00);
      chk("midrst_line1", line1, {16{8'h20}});
      chk("midrst_state", parser_state, ST_RSP_TEXT);
      srst_n = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_csn = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrst_no_strobe", n_valid - v0, 0);
      tx_q = '{8'h42};
      send_frame();
      model_blank();
      model_text(8'h42);
      chk("midrst_one_strobe", n_valid - v0, 1);
      chk("midrst_last_byte", bus.o_byte, 8'h42);
      chk_all("midrst");

      chk("exp_q_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
